// File: rtl/lcd_nibble_receiver.sv
// lcd_nibble_receiver: snoops a 4-bit HD44780 write bus and keeps a 32-cell shadow of the display
module lcd_nibble_receiver (
  input  logic       CCLK,
  input  logic       rst,
  input  logic       LCDE,
  input  logic       LCDRS,
  input  logic       LCDRW,
  input  logic [3:0] LCDDAT,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       byte_rs,
  output logic [4:0] cursor,
  output logic       mode4,
  output logic       err
);
  typedef enum logic [1:0] {INIT8, HI, LO} state_t;
  state_t      state;
  logic        lcde_q;
  logic        hi_rs;
  logic [3:0]  hi_nib;
  logic [7:0]  cells [32];
  logic [31:0] valid;
  logic        strobe;
  logic        commit;
  logic [7:0]  byte_in;
  assign strobe  = lcde_q & ~LCDE;
  assign byte_in = {hi_nib, LCDDAT};
  assign commit  = strobe & ~LCDRW & (state == LO) & (LCDRS == hi_rs);
  assign rd_char = valid[rd_addr] ? cells[rd_addr] : 8'h20;
  // cell storage needs no reset; the valid bits decide what is visible
  always_ff @(posedge CCLK)
    if (!rst && commit && LCDRS) cells[cursor] <= byte_in;
  always_ff @(posedge CCLK) begin
    if (rst) begin
      state      <= INIT8;
      lcde_q     <= 1'b0;
      hi_nib     <= '0;
      hi_rs      <= 1'b0;
      mode4      <= 1'b0;
      err        <= 1'b0;
      byte_valid <= 1'b0;
      byte_out   <= '0;
      byte_rs    <= 1'b0;
      cursor     <= '0;
      valid      <= '0;
    end else begin
      lcde_q     <= LCDE;
      byte_valid <= commit;
      if (strobe && LCDRW) err <= 1'b1;
      else if (strobe)
        case (state)
          INIT8: if (!LCDRS && LCDDAT == 4'h2) begin
            state <= HI;
            mode4 <= 1'b1;
          end
          HI: begin
            hi_nib <= LCDDAT;
            hi_rs  <= LCDRS;
            state  <= LO;
          end
          default: begin
            state <= HI;
            if (LCDRS != hi_rs) err <= 1'b1;
          end
        endcase
      if (commit) begin
        byte_out <= byte_in;
        byte_rs  <= LCDRS;
        if (LCDRS) begin
          valid[cursor] <= 1'b1;
          cursor        <= cursor + 5'd1;
        end else if (byte_in == 8'h01) begin
          valid  <= '0;
          cursor <= '0;
        end else if (byte_in[7:1] == 7'h01) cursor <= '0;
        else if (byte_in[7]) cursor <= {byte_in[6], byte_in[3:0]};
      end
    end
  end
endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// tb_lcd_nibble_receiver: directed and random nibble traffic checked against a display-level model
module tb_lcd_nibble_receiver;
  logic       CCLK = 0, rst = 1, LCDE = 0, LCDRS = 0, LCDRW = 0;
  logic [3:0] LCDDAT = 0;
  logic [4:0] rd_addr = 0;
  logic [7:0] rd_char, byte_out;
  logic       byte_valid, byte_rs, mode4, err;
  logic [4:0] cursor;
  int vectors = 0, miscompares = 0;
  logic [7:0] mem [32];
  int  m_cur, m_pend;
  bit  m_mode4, m_err, m_prs, m_brs;
  logic [7:0] m_bo;

  lcd_nibble_receiver dut (.CCLK(CCLK), .rst(rst), .LCDE(LCDE), .LCDRS(LCDRS), .LCDRW(LCDRW),
    .LCDDAT(LCDDAT), .rd_addr(rd_addr), .rd_char(rd_char), .byte_valid(byte_valid),
    .byte_out(byte_out), .byte_rs(byte_rs), .cursor(cursor), .mode4(mode4), .err(err));

  always #5 CCLK = ~CCLK;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) mem[i] = 8'h20;
    m_cur = 0; m_pend = -1; m_mode4 = 0; m_err = 0; m_prs = 0; m_brs = 0; m_bo = 0;
  endtask

  task automatic m_apply(input bit rs, input int b);
    int a;
    if (rs) begin
      mem[m_cur] = 8'(b);
      m_cur = (m_cur + 1) % 32;
    end else if (b == 1) begin
      for (int i = 0; i < 32; i++) mem[i] = 8'h20;
      m_cur = 0;
    end else if (b == 2 || b == 3) m_cur = 0;
    else if (b >= 128) begin
      a = b - 128;
      m_cur = (a >= 64 ? 16 : 0) + a % 16;
    end
  endtask

  task automatic m_step(input bit rs, input bit rw, input int d, output bit c);
    int b;
    c = 0;
    if (rw) m_err = 1;
    else if (!m_mode4) begin
      if (!rs && d == 2) m_mode4 = 1;
    end else if (m_pend < 0) begin
      m_pend = d;
      m_prs = rs;
    end else begin
      b = m_pend * 16 + d;
      m_pend = -1;
      if (rs != m_prs) m_err = 1;
      else begin
        c = 1;
        m_bo = 8'(b);
        m_brs = rs;
        m_apply(rs, b);
      end
    end
  endtask

  task automatic check_state(input string tag, input bit bv);
    chk({tag, ".byte_valid"}, byte_valid, bv);
    chk({tag, ".byte_out"}, byte_out, m_bo);
    chk({tag, ".byte_rs"}, byte_rs, m_brs);
    chk({tag, ".cursor"}, cursor, m_cur);
    chk({tag, ".mode4"}, mode4, m_mode4);
    chk({tag, ".err"}, err, m_err);
  endtask

  task automatic nib(input bit rs, input bit rw, input logic [3:0] d);
    bit c;
    @(posedge CCLK); #1;
    LCDE = 1; LCDRS = rs; LCDRW = rw; LCDDAT = d;
    @(posedge CCLK); #1;
    LCDE = 0;
    m_step(rs, rw, int'(d), c);
    @(posedge CCLK); #1;
    check_state("nib", c);
    @(posedge CCLK); #1;
    chk("pulse_width", byte_valid, 0);
  endtask

  task automatic send(input bit rs, input logic [7:0] b);
    nib(rs, 0, b[7:4]);
    nib(rs, 0, b[3:0]);
  endtask

  task automatic scan(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      #1;
      chk(tag, rd_char, mem[i]);
    end
  endtask

  task automatic do_reset(input bit with_strobe);
    @(posedge CCLK); #1;
    if (with_strobe) begin
      LCDE = 1; LCDRS = 0; LCDRW = 0; LCDDAT = 4'h2;
      @(posedge CCLK); #1;
      LCDE = 0;
    end
    rst = 1;
    @(posedge CCLK); #1;
    rst = 0;
    m_reset();
    check_state("reset", 0);
  endtask

  initial begin
    bit rs;
    logic [7:0] b;
    m_reset();
    @(posedge CCLK); #1;
    do_reset(0);
    scan("reset_rd_char");
    nib(0, 0, 4'h3); nib(0, 0, 4'h3); nib(0, 0, 4'h3); nib(0, 0, 4'h2);
    send(1, 8'h41); send(1, 8'h42);
    scan("data_write");
    send(0, 8'hCF); send(1, 8'h5A); send(1, 8'h5B);
    scan("addr_wrap");
    send(0, 8'h80);
    send(1, 8'h10); send(1, 8'h11); send(1, 8'h12); send(1, 8'h13);
    send(0, 8'h45); send(0, 8'h02); send(0, 8'h93); send(0, 8'h03);
    scan("pre_clear");
    send(0, 8'h01);
    scan("clear");
    nib(1, 1, 4'h7);
    send(1, 8'h61);
    nib(0, 0, 4'h4); nib(1, 0, 4'h1);
    send(1, 8'h62);
    scan("after_err");
    do_reset(0);
    nib(0, 0, 4'h2);
    nib(1, 0, 4'h4);
    do_reset(0);
    nib(0, 0, 4'h2);
    send(1, 8'h41);
    scan("reset_mid_byte");
    do_reset(1);
    nib(0, 0, 4'h2);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset($urandom_range(0, 1) == 1);
        nib(0, 0, 4'h2);
      end
      rs = 1'($urandom_range(0, 1));
      b = 8'($urandom);
      if ($urandom_range(0, 30) == 0) nib(rs, 1, 4'($urandom));
      if ($urandom_range(0, 15) == 0) begin
        nib(rs, 0, b[7:4]);
        nib(~rs, 0, b[3:0]);
      end else send(rs, b);
      if (n % 50 == 49) scan("random_scan");
    end
    scan("final_scan");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
